// File: rtl/teller_dispatcher_if.sv
// Bus bundle between the teller dispatcher and its surroundings: customer
// ticket button, teller-ready buttons, queue-counter flags and the
// call/display outputs.
// master : the environment (buttons, queue counter, display)
// slave  : the dispatcher itself
interface teller_dispatcher_if;
   logic       arrive;
   logic [3:0] ready;
   logic       full_flag;
   logic       empty_flag;
   logic       up;
   logic       down;
   logic       call_valid;
   logic [1:0] window;
   logic [6:0] ticket_in;
   logic [6:0] serving;
   logic [3:0] pending;

   modport master (
      output arrive, ready, full_flag, empty_flag,
      input  up, down, call_valid, window, ticket_in, serving, pending
   );

   modport slave (
      input  arrive, ready, full_flag, empty_flag,
      output up, down, call_valid, window, ticket_in, serving, pending
   );
endinterface

// File: rtl/teller_dispatcher.sv
// Teller dispatcher: issues tickets on customer arrival, latches teller-ready
// requests and calls the next customer to a free window, holding the called
// window on display for HOLD_CYCLES cycles.
//
// Build option: define RR_ARB_EN for round-robin window arbitration (search
// starts after the last called window). Without it, the lowest pending
// window index wins and no round-robin pointer exists.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a pending teller with a non-empty queue
// CALL  | one cycle: down + call_valid pulse, window/serving updated
// HOLD  | called window on display for HOLD_CYCLES cycles, no calls
module teller_dispatcher #(
   parameter int unsigned HOLD_CYCLES = 8
) (
   input logic                clk,
   input logic                reset,
   teller_dispatcher_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALL = 2'd1,
      HOLD = 2'd2
   } state_t;

   // HOLD lasts HOLD_CYCLES cycles: the down-counter is loaded with N-1 and
   // the terminal count (zero) is the last HOLD cycle.
   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] hold_cnt;
   logic [7:0] hold_cnt_nxt;
   logic       start_call;

   logic       arrive_q;
   logic [3:0] ready_q;
   logic       arr_edge;
   logic [3:0] rdy_edge;
   logic       take_arrival;

   logic       up_r;
   logic [6:0] ticket_r;
   logic [6:0] serving_r;
   logic [1:0] window_r;
   logic [3:0] pending_r;
   logic [1:0] grant;
   logic [3:0] clr_mask;

   // Ticket numbers are two decimal digits held in binary; 99 rolls to 0.
   function automatic logic [6:0] inc_ticket(input logic [6:0] v);
      return (v >= 7'd99) ? 7'd0 : v + 7'd1;
   endfunction

   // A button that is already high when reset releases still yields an edge,
   // because the history registers are cleared by reset.
   assign arr_edge     = bus.arrive & ~arrive_q;
   assign rdy_edge     = bus.ready & ~ready_q;
   assign take_arrival = arr_edge & ~bus.full_flag;

   // Input history for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         arrive_q <= 1'b0;
         ready_q  <= 4'b0000;
      end else begin
         arrive_q <= bus.arrive;
         ready_q  <= bus.ready;
      end
   end

   // Ticket issue: an accepted arrival pulses up and bumps the ticket together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         up_r     <= 1'b0;
         ticket_r <= 7'd0;
      end else begin
         up_r <= take_arrival;
         if (take_arrival) begin
            ticket_r <= inc_ticket(ticket_r);
         end
      end
   end

`ifdef RR_ARB_EN
   logic [1:0] rr_ptr;
   logic [1:0] rr_cand;
   logic       rr_found;

   // Round-robin pick: first pending window at or after the pointer, wrapping 3 -> 0.
   always_comb begin
      grant    = rr_ptr;
      rr_cand  = rr_ptr;
      rr_found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rr_cand = rr_ptr + 2'(k);
         if (!rr_found && pending_r[rr_cand]) begin
            grant    = rr_cand;
            rr_found = 1'b1;
         end
      end
   end

   // Pointer moves to the window after the one just called.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= 2'd0;
      end else if (start_call) begin
         rr_ptr <= grant + 2'd1;
      end
   end
`else
   // Fixed priority pick: lowest pending window index wins.
   always_comb begin
      grant = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending_r[i]) begin
            grant = 2'(i);
         end
      end
   end
`endif

   assign clr_mask = start_call ? (4'b0001 << grant) : 4'b0000;

   // Pending requests: set on a ready edge, cleared when that window is called.
   // Clearing wins so an edge coinciding with the call does not re-arm it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_r <= 4'b0000;
      end else begin
         pending_r <= (pending_r | rdy_edge) & ~clr_mask;
      end
   end

   // Call datapath: window and serving change only when a call is launched,
   // so both are already valid during the CALL cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         window_r  <= 2'd0;
         serving_r <= 7'd0;
      end else if (start_call) begin
         window_r  <= grant;
         serving_r <= inc_ticket(serving_r);
      end
   end

   // FSM state and hold timer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // FSM next state. A cycle with an arrival edge never launches a call, which
   // keeps up and down from ever pulsing together.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      start_call   = 1'b0;
      unique case (state)
         IDLE: begin
            if ((pending_r != 4'b0000) && !bus.empty_flag && !arr_edge) begin
               state_nxt  = CALL;
               start_call = 1'b1;
            end
         end
         CALL: begin
            state_nxt    = HOLD;
            hold_cnt_nxt = HOLD_LOAD;
         end
         HOLD: begin
            if (hold_cnt == 8'd0) begin
               state_nxt = IDLE;
            end else begin
               hold_cnt_nxt = hold_cnt - 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.up         = up_r;
   assign bus.down       = (state == CALL);
   assign bus.call_valid = (state == CALL);
   assign bus.window     = window_r;
   assign bus.ticket_in  = ticket_r;
   assign bus.serving    = serving_r;
   assign bus.pending    = pending_r;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Testbench for teller_dispatcher: directed scenarios plus a randomized run.
// A reference model of the ticket/call rules predicts up pulses and calls;
// a monitor compares those predictions against the DUT every cycle.
module tb_teller_dispatcher;

   localparam int HOLD = 8;

   logic clk;
   logic reset;

   teller_dispatcher_if bus ();

   teller_dispatcher #(.HOLD_CYCLES(HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // expected up pulses (ticket value) and calls ({window, serving})
   logic [6:0] up_q[$];
   logic [8:0] call_q[$];

   // reference model state
   int         m_ticket;
   int         m_serving;
   int         m_window;
   int         m_ptr;
   logic [3:0] m_pend;
   logic       m_arr_q;
   logic [3:0] m_rdy_q;
   int         m_cycle;
   int         m_free;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] p, input int start);
      for (int k = 0; k < 4; k++) begin
         if (p[(start + k) % 4]) return (start + k) % 4;
      end
      return 0;
   endfunction

   task automatic cyc();
      @(negedge clk);
      #2;
   endtask

   // Reference model + monitor. Inputs only change at negedge+2, so at each
   // negedge they still hold the values the DUT sampled at the previous posedge.
   initial begin
      bit         aedge;
      int         w;
      logic [3:0] clr;
      logic [8:0] ce;
      bit         exp_up;
      bit         exp_call;
      m_ticket = 0; m_serving = 0; m_window = 0; m_ptr = 0;
      m_pend = 4'b0; m_arr_q = 1'b0; m_rdy_q = 4'b0; m_cycle = 0; m_free = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            m_ticket = 0; m_serving = 0; m_window = 0; m_ptr = 0;
            m_pend = 4'b0; m_arr_q = 1'b0; m_rdy_q = 4'b0; m_free = 0;
            up_q.delete();
            call_q.delete();
         end else begin
            aedge = bus.arrive && !m_arr_q;
            if (aedge && !bus.full_flag) begin
               m_ticket = (m_ticket + 1) % 100;
               up_q.push_back(7'(m_ticket));
            end
            clr = 4'b0;
            if (m_cycle >= m_free && m_pend != 4'b0 && !bus.empty_flag && !aedge) begin
`ifdef RR_ARB_EN
               w = pick(m_pend, m_ptr);
`else
               w = pick(m_pend, 0);
`endif
               m_ptr     = (w + 1) % 4;
               m_window  = w;
               m_serving = (m_serving + 1) % 100;
               call_q.push_back({2'(w), 7'(m_serving)});
               m_free = m_cycle + HOLD + 2;
               clr[w] = 1'b1;
            end
            m_pend  = (m_pend | (bus.ready & ~m_rdy_q)) & ~clr;
            m_arr_q = bus.arrive;
            m_rdy_q = bus.ready;
            m_cycle++;

            exp_up   = (up_q.size() != 0);
            exp_call = (call_q.size() != 0);
            check("mon_up", int'(bus.up), int'(exp_up));
            if (exp_up && bus.up) begin
               check("mon_up_ticket", int'(bus.ticket_in), int'(up_q.pop_front()));
            end
            check("mon_call_valid", int'(bus.call_valid), int'(exp_call));
            check("mon_down", int'(bus.down), int'(exp_call));
            if (exp_call && bus.call_valid) begin
               ce = call_q.pop_front();
               check("mon_call_window", int'(bus.window), int'(ce[8:7]));
               check("mon_call_serving", int'(bus.serving), int'(ce[6:0]));
            end
            up_q.delete();
            call_q.delete();
            check("mon_up_down_excl", int'(bus.up && bus.down), 0);
            check("mon_ticket", int'(bus.ticket_in), m_ticket);
            check("mon_serving", int'(bus.serving), m_serving);
            check("mon_window", int'(bus.window), m_window);
            check("mon_pending", int'(bus.pending), int'(m_pend));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_up"}, int'(bus.up), 0);
      check({tag, "_down"}, int'(bus.down), 0);
      check({tag, "_call_valid"}, int'(bus.call_valid), 0);
      check({tag, "_window"}, int'(bus.window), 0);
      check({tag, "_ticket"}, int'(bus.ticket_in), 0);
      check({tag, "_serving"}, int'(bus.serving), 0);
      check({tag, "_pending"}, int'(bus.pending), 0);
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      int   ncall;
      int   call_cyc[8];
      int   call_win[8];
      bit   found;
      logic [3:0] tog;

      reset = 1'b0;
      bus.arrive = 1'b0; bus.ready = 4'b0; bus.full_flag = 1'b0; bus.empty_flag = 1'b1;
      #1 reset = 1'b1;
      #1 check_all_zero("reset");
      cyc(); cyc();
      reset = 1'b0;

      // arrival accepted, then dropped while full
      cyc();
      bus.arrive = 1'b1;
      cyc();
      check("arr_up", int'(bus.up), 1);
      check("arr_ticket", int'(bus.ticket_in), 1);
      bus.arrive = 1'b0;
      cyc();
      check("arr_up_one_cycle", int'(bus.up), 0);
      bus.full_flag = 1'b1; bus.arrive = 1'b1;
      cyc();
      check("full_no_up", int'(bus.up), 0);
      check("full_ticket", int'(bus.ticket_in), 1);
      bus.arrive = 1'b0; bus.full_flag = 1'b0;
      cyc();

      // single call latency on window 2
      bus.empty_flag = 1'b0;
      bus.ready = 4'b0100;
      cyc();
      check("lat_pending", int'(bus.pending), 4);
      check("lat_no_down_yet", int'(bus.down), 0);
      cyc();
      check("lat_down", int'(bus.down), 1);
      check("lat_call_valid", int'(bus.call_valid), 1);
      check("lat_window", int'(bus.window), 2);
      check("lat_serving", int'(bus.serving), 1);
      check("lat_pending_clr", int'(bus.pending), 0);
      bus.ready = 4'b0;
      repeat (HOLD + 4) cyc();

      // three simultaneous requests: order 0,1,3 spaced HOLD+2 cycles
      bus.ready = 4'b1011;
      ncall = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (bus.call_valid && ncall < 8) begin
            call_cyc[ncall] = i;
            call_win[ncall] = int'(bus.window);
            ncall++;
         end
      end
      bus.ready = 4'b0;
      check("multi_count", ncall, 3);
      if (ncall >= 3) begin
         check("multi_win0", call_win[0], 0);
         check("multi_win1", call_win[1], 1);
         check("multi_win2", call_win[2], 3);
         check("multi_gap01", call_cyc[1] - call_cyc[0], HOLD + 2);
         check("multi_gap12", call_cyc[2] - call_cyc[1], HOLD + 2);
      end
      repeat (4) cyc();

      // call window 1, then 0 and 1 pending: next call goes to window 0
      bus.ready = 4'b0010;
      cyc();
      check("wrap_pending1", int'(bus.pending), 2);
      cyc();
      check("wrap_call1", int'(bus.call_valid), 1);
      check("wrap_win1", int'(bus.window), 1);
      bus.ready = 4'b0;
      cyc();
      bus.ready = 4'b0011;
      cyc();
      check("wrap_pending3", int'(bus.pending), 3);
      found = 1'b0;
      for (int i = 0; i < 15 && !found; i++) begin
         cyc();
         if (bus.call_valid) found = 1'b1;
      end
      check("wrap_call_seen", int'(found), 1);
      check("wrap_next_win", int'(bus.window), 0);
      bus.ready = 4'b0;
      repeat (2 * HOLD + 6) cyc();

      // empty queue blocks calls, pending preserved
      bus.empty_flag = 1'b1;
      bus.ready = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         cyc();
         check("empty_no_down", int'(bus.down), 0);
      end
      check("empty_pending0", int'(bus.pending[0]), 1);
      bus.empty_flag = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2 && !found; i++) begin
         cyc();
         if (bus.down) found = 1'b1;
      end
      check("empty_release_call", int'(found), 1);
      check("empty_release_win", int'(bus.window), 0);
      bus.ready = 4'b0;
      repeat (HOLD + 4) cyc();

      // 100 arrivals: ticket wraps 99 -> 0
      for (int k = 1; k <= 100; k++) begin
         bus.arrive = 1'b1;
         cyc();
         check("wrap_ticket", int'(bus.ticket_in), (1 + k) % 100);
         bus.arrive = 1'b0;
         cyc();
      end

      // reset during HOLD, arrive held through release
      bus.ready = 4'b0100;
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         cyc();
         if (bus.call_valid) found = 1'b1;
      end
      check("rst_call_seen", int'(found), 1);
      repeat (3) cyc();
      reset = 1'b1;
      bus.arrive = 1'b1;
      #1 check_all_zero("rst_hold");
      cyc();
      reset = 1'b0;
      cyc();
      check("rst_release_up", int'(bus.up), 1);
      check("rst_release_ticket", int'(bus.ticket_in), 1);
      bus.arrive = 1'b0;
      bus.ready = 4'b0;
      repeat (2 * HOLD + 6) cyc();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 499) == 0) begin
            reset = 1'b1;
         end
         bus.arrive = 1'($urandom_range(0, 1));
         tog = 4'b0;
         for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 7) == 0);
         bus.ready      = bus.ready ^ tog;
         bus.full_flag  = ($urandom_range(0, 7) == 0);
         bus.empty_flag = ($urandom_range(0, 5) == 0);
      end
      reset = 1'b0;
      bus.arrive = 1'b0; bus.ready = 4'b0; bus.full_flag = 1'b0; bus.empty_flag = 1'b0;
      repeat (60) cyc();
      check("drain_pending", int'(bus.pending), 0);
      check("drain_idle", int'(bus.call_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
